// File: rtl/neuron_core_lif_param_pkg.sv
// Shared types for the parametrised LIF neuron core: OBI structs, FSM/arbiter
// enums and word-field helpers for the neuron SRAM layout.
package neuron_core_lif_param_pkg;

  localparam int unsigned OBI_AW = 32;
  localparam int unsigned OBI_DW = 32;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [OBI_AW-1:0]     addr;
    logic [OBI_DW-1:0]     wdata;
    logic [OBI_DW/8-1:0]   be;
  } req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [OBI_DW-1:0] rdata;
  } rsp_t;

  typedef enum logic [1:0] {IDLE, RD, WB} fsm_e;
  typedef enum logic {ARB_EV, ARB_OBI} arb_e;

  // Word layout from LSB: state, threshold, leak, disable
  function automatic int unsigned thr_lsb(input int unsigned state_w);
    return state_w;
  endfunction

  function automatic int unsigned leak_lsb(input int unsigned state_w);
    return 2 * state_w;
  endfunction

  function automatic int unsigned dis_bit(input int unsigned state_w, input int unsigned leak_w);
    return 2 * state_w + leak_w;
  endfunction

  function automatic logic [OBI_DW-1:0] fld(input logic [OBI_DW-1:0] word,
                                            input int unsigned lsb,
                                            input int unsigned width);
    logic [OBI_DW-1:0] mask;
    mask = (OBI_DW'(1) << width) - OBI_DW'(1);
    return (word >> lsb) & mask;
  endfunction

endpackage

// File: rtl/neuron_core_lif_param_if.sv
// Event handshake between the scheduler (master) and the neuron core (slave).
interface neuron_core_lif_param_if #(
  parameter int unsigned AW       = 8,
  parameter int unsigned WEIGHT_W = 4
);
  logic                ev_valid_i;
  logic                ev_ready_o;
  logic [AW-1:0]       ev_idx_i;
  logic                ev_tref_i;
  logic [WEIGHT_W-1:0] ev_weight_i;

  modport master (output ev_valid_i, ev_idx_i, ev_tref_i, ev_weight_i, input ev_ready_o);
  modport slave  (input ev_valid_i, ev_idx_i, ev_tref_i, ev_weight_i, output ev_ready_o);
endinterface

// File: rtl/neuron_core_lif_param_lif_update.sv
// Combinational LIF update: saturating synaptic integration with threshold
// spike, or symmetric leak toward zero; disabled neurons pass through.
module lif_update_param #(
  parameter int unsigned STATE_W  = 12,
  parameter int unsigned LEAK_W   = 7,
  parameter int unsigned WEIGHT_W = 4
) (
  input  logic [STATE_W-1:0]  i_state,
  input  logic [STATE_W-1:0]  i_thr,
  input  logic [LEAK_W-1:0]   i_leak,
  input  logic [WEIGHT_W-1:0] i_weight,
  input  logic                i_tref,
  input  logic                i_disable,
  output logic [STATE_W-1:0]  o_next,
  output logic                o_spike
);
  localparam int unsigned MW0 = (STATE_W > LEAK_W) ? STATE_W : LEAK_W;
  localparam int unsigned IW  = ((MW0 > WEIGHT_W) ? MW0 : WEIGHT_W) + 2;
  localparam logic signed [IW-1:0] SMAX = (IW'(1) << (STATE_W - 1)) - IW'(1);
  localparam logic signed [IW-1:0] SMIN = -SMAX - IW'(1);

  logic signed [IW-1:0] w_st, w_lk, w_wt, w_thr, w_sum, w_sat, w_leaked;

  always_comb begin
    w_st  = {{(IW-STATE_W){i_state[STATE_W-1]}}, i_state};
    w_wt  = {{(IW-WEIGHT_W){i_weight[WEIGHT_W-1]}}, i_weight};
    w_lk  = IW'(i_leak);
    w_thr = IW'(i_thr);
    w_sum = w_st + w_wt;
    if (w_sum > SMAX)      w_sat = SMAX;
    else if (w_sum < SMIN) w_sat = SMIN;
    else                   w_sat = w_sum;
    if (w_st > w_lk)       w_leaked = w_st - w_lk;
    else if (w_st < -w_lk) w_leaked = w_st + w_lk;
    else                   w_leaked = '0;
  end

  always_comb begin
    o_next  = i_state;
    o_spike = 1'b0;
    if (!i_disable) begin
      if (i_tref) begin
        o_next = STATE_W'(w_leaked);
      end else if (w_sat >= w_thr) begin
        o_spike = 1'b1;
        o_next  = '0;
      end else begin
        o_next = STATE_W'(w_sat);
      end
    end
  end
endmodule

// File: rtl/neuron_core_lif_param_sram.sv
// Behavioural single-port SRAM with synchronous read; Q holds between reads.
module sram_1p_wrapper #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_cs,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_cs) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/neuron_core_lif_param.sv
// Time-multiplexed LIF neuron array: event RMW FSM and OBI slave sharing one
// single-port neuron SRAM under round-robin arbitration.
module neuron_core_lif_param
  import neuron_core_lif_param_pkg::*;
#(
  parameter int unsigned N        = 256,
  parameter int unsigned STATE_W  = 12,
  parameter int unsigned LEAK_W   = 7,
  parameter int unsigned WEIGHT_W = 4,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned AW       = $clog2(N)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  neuron_core_lif_param_if.slave ev,
  output logic                   spike_valid_o,
  output logic [AW-1:0]          spike_idx_o,
  input  req_t                   obi_req_i,
  output rsp_t                   obi_rsp_o
);
  localparam int unsigned THR_LSB  = thr_lsb(STATE_W);
  localparam int unsigned LEAK_LSB = leak_lsb(STATE_W);
  localparam int unsigned DIS_BIT  = dis_bit(STATE_W, LEAK_W);

  if (WORD_W != 1 + LEAK_W + 2 * STATE_W) begin : g_bad_word
    $error("WORD_W must equal 1+LEAK_W+2*STATE_W");
  end
  if (WORD_W > OBI_DW) begin : g_bad_obi
    $error("WORD_W must fit the OBI data bus");
  end

  fsm_e                r_state;
  arb_e                r_rr_last;
  logic [AW-1:0]       r_idx;
  logic                r_tref;
  logic [WEIGHT_W-1:0] r_weight;
  logic                r_rvalid;
  logic                r_rd_pend;
  logic                r_spike_valid;
  logic [AW-1:0]       r_spike_idx;

  logic                w_ev_ready, w_gnt, w_ev_fire;
  logic                w_cs, w_we;
  logic [AW-1:0]       w_addr, w_obi_addr;
  logic [WORD_W-1:0]   w_wdata, w_q;
  logic [STATE_W-1:0]  w_q_state, w_q_thr, w_next;
  logic [LEAK_W-1:0]   w_q_leak;
  logic                w_q_dis, w_spike;
  logic                w_unused_obi;

  assign w_obi_addr   = obi_req_i.addr[AW+1:2];
  assign w_unused_obi = ^{obi_req_i.be, obi_req_i.addr[OBI_AW-1:AW+2], obi_req_i.addr[1:0]};

  // Contested IDLE cycles go to whichever requester did not win last
  always_comb begin
    w_ev_ready = 1'b0;
    w_gnt      = 1'b0;
    if (RST_N && r_state == IDLE) begin
      w_ev_ready = !obi_req_i.req || (r_rr_last == ARB_OBI);
      w_gnt      = obi_req_i.req && (!ev.ev_valid_i || r_rr_last == ARB_EV);
    end
  end

  assign w_ev_fire     = ev.ev_valid_i && w_ev_ready;
  assign ev.ev_ready_o = w_ev_ready;

  assign w_q_state = w_q[STATE_W-1:0];
  assign w_q_thr   = STATE_W'(fld(OBI_DW'(w_q), THR_LSB, STATE_W));
  assign w_q_leak  = LEAK_W'(fld(OBI_DW'(w_q), LEAK_LSB, LEAK_W));
  assign w_q_dis   = w_q[DIS_BIT];

  lif_update_param #(
    .STATE_W  (STATE_W),
    .LEAK_W   (LEAK_W),
    .WEIGHT_W (WEIGHT_W)
  ) u_lif (
    .i_state   (w_q_state),
    .i_thr     (w_q_thr),
    .i_leak    (w_q_leak),
    .i_weight  (r_weight),
    .i_tref    (r_tref),
    .i_disable (w_q_dis),
    .o_next    (w_next),
    .o_spike   (w_spike)
  );

  // Chip select is gated by reset so an interrupted RMW never writes
  always_comb begin
    w_cs    = 1'b0;
    w_we    = 1'b0;
    w_addr  = r_idx;
    w_wdata = {w_q[WORD_W-1:STATE_W], w_next};
    case (r_state)
      IDLE: if (w_gnt) begin
        w_cs    = 1'b1;
        w_we    = obi_req_i.we;
        w_addr  = w_obi_addr;
        w_wdata = WORD_W'(obi_req_i.wdata);
      end
      RD: w_cs = 1'b1;
      WB: begin
        w_cs = 1'b1;
        w_we = 1'b1;
      end
      default: ;
    endcase
    if (!RST_N) w_cs = 1'b0;
  end

  sram_1p_wrapper #(
    .DEPTH (N),
    .WIDTH (WORD_W)
  ) u_sram (
    .i_clk   (CLK),
    .i_cs    (w_cs),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_q)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state       <= IDLE;
      r_rr_last     <= ARB_OBI;
      r_idx         <= '0;
      r_tref        <= 1'b0;
      r_weight      <= '0;
      r_rvalid      <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_spike_valid <= 1'b0;
      r_spike_idx   <= '0;
    end else begin
      r_rvalid      <= w_gnt;
      r_rd_pend     <= w_gnt && !obi_req_i.we;
      r_spike_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ev_fire) begin
            r_idx     <= ev.ev_idx_i;
            r_tref    <= ev.ev_tref_i;
            r_weight  <= ev.ev_weight_i;
            r_rr_last <= ARB_EV;
            r_state   <= RD;
          end else if (w_gnt) begin
            r_rr_last <= ARB_OBI;
          end
        end
        RD: r_state <= WB;
        WB: begin
          r_state <= IDLE;
          if (w_spike) begin
            r_spike_valid <= 1'b1;
            r_spike_idx   <= r_idx;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign spike_valid_o    = r_spike_valid;
  assign spike_idx_o      = r_spike_idx;
  assign obi_rsp_o.gnt    = w_gnt;
  assign obi_rsp_o.rvalid = r_rvalid;
  assign obi_rsp_o.rdata  = r_rd_pend ? OBI_DW'(w_q) : '0;
endmodule

// File: tb/tb_neuron_core_lif_param.sv
// Randomised bench for neuron_core_lif_param against an integer LIF model.
module tb_neuron_core_lif_param;
  import neuron_core_lif_param_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N;
  req_t       obi_req;
  rsp_t       obi_rsp;
  logic       spike_valid;
  logic [7:0] spike_idx;

  logic [31:0] mem [256];
  logic [7:0]  spike_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  neuron_core_lif_param_if #(.AW(8), .WEIGHT_W(4)) u_if ();

  neuron_core_lif_param #(
    .N (256), .STATE_W (12), .LEAK_W (7), .WEIGHT_W (4), .WORD_W (32)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .ev            (u_if),
    .spike_valid_o (spike_valid),
    .spike_idx_o   (spike_idx),
    .obi_req_i     (obi_req),
    .obi_rsp_o     (obi_rsp)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (spike_valid) spike_q.push_back(spike_idx);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input bit dis, input int leak, input int thr, input int st);
    return {dis, 7'(leak), 12'(thr), 12'(st)};
  endfunction

  // Reference LIF rule on plain integers; returns whether the neuron spikes.
  function automatic bit model_event(input int idx, input bit tref, input int w);
    logic [31:0] word;
    int st, leak, thr;
    bit sp;
    word = mem[idx];
    st   = $signed(word[11:0]);
    leak = int'(word[30:24]);
    thr  = int'(word[23:12]);
    sp   = 1'b0;
    if (!word[31]) begin
      if (tref) begin
        if (st > leak)       st = st - leak;
        else if (st < -leak) st = st + leak;
        else                 st = 0;
      end else begin
        st = st + w;
        if (st > 2047)  st = 2047;
        if (st < -2048) st = -2048;
        if (st >= thr) begin
          sp = 1'b1;
          st = 0;
        end
      end
    end
    mem[idx] = {word[31:12], 12'(st)};
    return sp;
  endfunction

  task automatic obi_xfer(input int a, input bit we, input logic [31:0] d, input bit alias_hi);
    bit ok = 1'b0;
    @(posedge CLK); #1;
    obi_req.req   = 1'b1;
    obi_req.we    = we;
    obi_req.addr  = (32'(a) << 2) | (alias_hi ? ($urandom & 32'hFFFF_FC00) : 32'h0);
    obi_req.wdata = d;
    obi_req.be    = 4'hF;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (obi_rsp.gnt) begin ok = 1'b1; break; end
    end
    chk(we ? "wr_gnt" : "rd_gnt", 32'(ok), 32'd1);
    @(posedge CLK); #1;
    obi_req.req = 1'b0;
    @(negedge CLK);
    chk(we ? "wr_rvalid" : "rd_rvalid", 32'(obi_rsp.rvalid), 32'd1);
    if (we) begin
      chk("wr_rdata", obi_rsp.rdata, 32'h0);
      if (ok) mem[a] = d;
    end else begin
      chk($sformatf("rd_data[%0d]", a), obi_rsp.rdata, mem[a]);
    end
  endtask

  task automatic obi_write(input int a, input logic [31:0] d);
    obi_xfer(a, 1'b1, d, 1'b0);
  endtask

  task automatic obi_read(input int a, input bit alias_hi);
    obi_xfer(a, 1'b0, 32'h0, alias_hi);
  endtask

  task automatic send_event(input int idx, input bit tref, input int w);
    bit ok = 1'b0;
    bit exp_sp;
    spike_q.delete();
    @(posedge CLK); #1;
    u_if.ev_valid_i  = 1'b1;
    u_if.ev_idx_i    = 8'(idx);
    u_if.ev_tref_i   = tref;
    u_if.ev_weight_i = 4'(w);
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (u_if.ev_ready_o) begin ok = 1'b1; break; end
    end
    chk("ev_accept", 32'(ok), 32'd1);
    @(posedge CLK); #1;
    u_if.ev_valid_i = 1'b0;
    exp_sp = ok ? model_event(idx, tref, w) : 1'b0;
    repeat (4) @(negedge CLK);
    chk("spike_cnt", 32'(spike_q.size()), 32'(exp_sp));
    if (exp_sp && spike_q.size() > 0) chk("spike_idx", 32'(spike_q[0]), 32'(idx));
    obi_read(idx, 1'b0);
  endtask

  initial begin
    int  n_grant;
    bit  have_prev, prev_ev, rd_pend;
    int  busy;
    RST_N            = 1'b0;
    u_if.ev_valid_i  = 1'b1;
    u_if.ev_idx_i    = '0;
    u_if.ev_tref_i   = 1'b0;
    u_if.ev_weight_i = '0;
    obi_req          = '0;
    obi_req.req      = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_ev_ready", 32'(u_if.ev_ready_o), 32'd0);
    chk("rst_gnt", 32'(obi_rsp.gnt), 32'd0);
    chk("rst_rvalid", 32'(obi_rsp.rvalid), 32'd0);
    chk("rst_rdata", obi_rsp.rdata, 32'h0);
    chk("rst_spike_valid", 32'(spike_valid), 32'd0);
    chk("rst_spike_idx", 32'(spike_idx), 32'd0);
    @(posedge CLK); #1;
    u_if.ev_valid_i = 1'b0;
    obi_req.req     = 1'b0;
    RST_N           = 1'b1;

    // 1: write/readback
    obi_write(5, mk(0, 3, 10, 0));
    obi_read(5, 1'b0);
    // 2: integrate to threshold
    repeat (3) send_event(5, 1'b0, 4);
    // 3: leak
    obi_write(9, mk(0, 3, 100, -2));  send_event(9, 1'b1, 0);
    obi_write(9, mk(0, 3, 100, 7));   send_event(9, 1'b1, 0);
    obi_write(9, mk(0, 3, 100, -9));  send_event(9, 1'b1, 0);
    // 4: saturation
    obi_write(10, mk(0, 0, 4095, 2045));  send_event(10, 1'b0, 7);
    obi_write(10, mk(0, 0, 4095, -2047)); send_event(10, 1'b0, -8);
    // 5: disabled neuron
    obi_write(11, mk(1, 0, 10, 9)); send_event(11, 1'b0, 7);

    // reset while in RD: no write, no spike
    obi_write(5, mk(0, 0, 10, 9));
    spike_q.delete();
    @(posedge CLK); #1;
    u_if.ev_valid_i  = 1'b1;
    u_if.ev_idx_i    = 8'd5;
    u_if.ev_tref_i   = 1'b0;
    u_if.ev_weight_i = 4'd4;
    begin
      bit ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge CLK);
        if (u_if.ev_ready_o) begin ok = 1'b1; break; end
      end
      chk("rstmid_accept", 32'(ok), 32'd1);
    end
    @(posedge CLK); #1;
    u_if.ev_valid_i = 1'b0;
    RST_N           = 1'b0;
    @(negedge CLK);
    chk("rstmid_ready", 32'(u_if.ev_ready_o), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("rstmid_spikes", 32'(spike_q.size()), 32'd0);
    obi_read(5, 1'b0);

    // 6: contested arbitration, first contest after reset goes to events
    obi_write(7, mk(0, 3, 50, 0));
    spike_q.delete();
    @(posedge CLK); #1;
    u_if.ev_valid_i  = 1'b1;
    u_if.ev_idx_i    = 8'd7;
    u_if.ev_tref_i   = 1'b1;
    u_if.ev_weight_i = '0;
    obi_req.req      = 1'b1;
    obi_req.we       = 1'b0;
    obi_req.addr     = 32'd7 << 2;
    n_grant = 0; have_prev = 1'b0; prev_ev = 1'b0; rd_pend = 1'b0; busy = 0;
    for (int c = 0; c < 16; c++) begin
      bit g_ev, g_obi;
      @(negedge CLK);
      if (rd_pend) begin
        chk("arb_rvalid", 32'(obi_rsp.rvalid), 32'd1);
        chk("arb_rdata", obi_rsp.rdata, mem[7]);
      end
      if (busy > 0) begin
        chk("arb_busy_ready", 32'(u_if.ev_ready_o), 32'd0);
        chk("arb_busy_gnt", 32'(obi_rsp.gnt), 32'd0);
        busy--;
      end
      g_ev  = u_if.ev_valid_i && u_if.ev_ready_o;
      g_obi = obi_rsp.gnt;
      rd_pend = g_obi;
      if (g_ev || g_obi) begin
        chk("arb_one_winner", 32'(g_ev && g_obi), 32'd0);
        if (!have_prev) chk("arb_first", 32'(g_ev), 32'd1);
        else            chk("arb_alt", 32'(g_ev), 32'(!prev_ev));
        have_prev = 1'b1;
        prev_ev   = g_ev;
        n_grant++;
        if (g_ev) begin
          void'(model_event(7, 1'b1, 0));
          busy = 2;
        end
      end
    end
    @(posedge CLK); #1;
    u_if.ev_valid_i = 1'b0;
    obi_req.req     = 1'b0;
    chk("arb_grant_cnt", 32'(n_grant >= 6), 32'd1);
    repeat (4) @(negedge CLK);
    chk("arb_spikes", 32'(spike_q.size()), 32'd0);
    obi_read(7, 1'b0);

    // random phase on a small neuron window
    for (int n = 0; n < 16; n++)
      obi_write(n, mk($urandom_range(7) == 0, $urandom_range(127), $urandom_range(300),
                      int'($urandom_range(4095)) - 2048));
    for (int k = 0; k < 60; k++) begin
      int idx;
      idx = $urandom_range(15);
      if ($urandom_range(9) < 7)
        send_event(idx, $urandom_range(3) == 0, int'($urandom_range(15)) - 8);
      else
        obi_read(idx, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
